// File: rtl/seg_scan_driver.sv
// Multi-digit seven-segment driver: sequential double-dabble BCD conversion plus a
// free-running digit scan. Define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int SCAN_DIV   = 10000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(VALUE_W + 1);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

    state_t                state_q, state_d;
    logic [VALUE_W-1:0]    val_q, val_d;
    logic [BW-1:0]         bcd_q, bcd_d;
    logic [BW-1:0]         bcd_adj;
    logic                  ovf_acc_q, ovf_acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         disp_q, disp_d;
    logic                  ovf_q, ovf_d;
    logic [PW-1:0]         pre_q, pre_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [NUM_DIGITS-1:0] blank;
    logic                  tick;

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'd0:    font = 7'b0000001;
            4'd1:    font = 7'b1001111;
            4'd2:    font = 7'b0010010;
            4'd3:    font = 7'b0000110;
            4'd4:    font = 7'b1001100;
            4'd5:    font = 7'b0100100;
            4'd6:    font = 7'b0100000;
            4'd7:    font = 7'b0001111;
            4'd8:    font = 7'b0000000;
            4'd9:    font = 7'b0000100;
            default: font = SEG_BLANK;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (load) state_d = S_SHIFT;
            S_SHIFT:  if (cnt_q == CW'(VALUE_W - 1)) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Double-dabble step; a bit leaving the top nibble means the value needs more digits.
    always_comb begin
        val_d     = val_q;
        bcd_d     = bcd_q;
        ovf_acc_d = ovf_acc_q;
        cnt_d     = cnt_q;
        disp_d    = disp_q;
        ovf_d     = ovf_q;
        bcd_adj   = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    val_d     = value;
                    bcd_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            S_SHIFT: begin
                bcd_d     = {bcd_adj[BW-2:0], val_q[VALUE_W-1]};
                ovf_acc_d = ovf_acc_q | bcd_adj[BW-1];
                val_d     = val_q << 1;
                cnt_d     = cnt_q + CW'(1);
            end
            S_COMMIT: begin
                disp_d = bcd_q;
                ovf_d  = ovf_acc_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        blank = '0;
`ifdef SEG_LZB_EN
        begin
            logic run;
            run = 1'b1;
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                run      = run & (disp_q[4*i +: 4] == 4'd0);
                blank[i] = run;
            end
            if (ovf_q) blank = '0;
        end
`endif
    end

    assign tick = (pre_q == PW'(SCAN_DIV - 1));

    // The output register latches the current index on a tick, then the index moves on.
    always_comb begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        idx_d = idx_q;
        seg_d = seg_q;
        an_d  = an_q;
        if (tick) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
            an_d  = '1;
            seg_d = SEG_BLANK;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == IW'(i)) begin
                    an_d[i] = 1'b0;
                    if (ovf_q)         seg_d = SEG_DASH;
                    else if (blank[i]) seg_d = SEG_BLANK;
                    else               seg_d = font(disp_q[4*i +: 4]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q     <= '0;
            bcd_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            pre_q     <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_BLANK;
            an_q      <= '1;
        end else begin
            val_q     <= val_d;
            bcd_q     <= bcd_d;
            ovf_acc_q <= ovf_acc_d;
            cnt_q     <= cnt_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign overflow = ovf_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (4 digits, 14-bit value, 4-cycle dwell);
// expectations come from a decimal reference model and are queued when stimulus is driven.
module tb_seg_scan_driver;
    localparam int NUM_DIGITS = 4;
    localparam int VALUE_W    = 14;
    localparam int SCAN_DIV   = 4;
    localparam int W          = 11;
    localparam int LIM        = 10000;

    logic                  clk   = 1'b0;
    logic                  rst   = 1'b1;
    logic                  load  = 1'b0;
    logic [VALUE_W-1:0]    value = '0;
    logic                  busy;
    logic                  overflow;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] an;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    string        tag_q[$];

    seg_scan_driver #(
        .NUM_DIGITS(NUM_DIGITS),
        .VALUE_W   (VALUE_W),
        .SCAN_DIV  (SCAN_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .load    (load),
        .busy    (busy),
        .overflow(overflow),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] font(input int d);
        case (d)
            0:       font = 7'b0000001;
            1:       font = 7'b1001111;
            2:       font = 7'b0010010;
            3:       font = 7'b0000110;
            4:       font = 7'b1001100;
            5:       font = 7'b0100100;
            6:       font = 7'b0100000;
            7:       font = 7'b0001111;
            8:       font = 7'b0000000;
            9:       font = 7'b0000100;
            default: font = 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int i);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (v >= LIM) return 7'b1111110;
`ifdef SEG_LZB_EN
        if (i > 0 && v < p) return 7'b1111111;
`endif
        return font((v / p) % 10);
    endfunction

    function automatic logic [NUM_DIGITS-1:0] an_exp(input int i);
        return ~(NUM_DIGITS'(1) << i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [W-1:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_obs(input logic [W-1:0] obs);
        logic [W-1:0] e;
        string        t;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic push_display(input int v, input string name);
        expect_val({name, "_ovf"}, W'(v >= LIM));
        for (int i = 0; i < NUM_DIGITS; i++)
            expect_val($sformatf("%s_d%0d", name, i), {an_exp(i), exp_seg(v, i)});
    endtask

    task automatic next_dwell(output logic [W-1:0] obs);
        logic [NUM_DIGITS-1:0] prev;
        prev = an;
        for (int k = 0; k < 3 * SCAN_DIV; k++) begin
            step();
            if (an !== prev) break;
        end
        obs = {an, seg};
    endtask

    task automatic collect_display();
        logic [W-1:0] obs;
        check_obs(W'(overflow));
        next_dwell(obs);
        for (int k = 0; k < NUM_DIGITS && obs[W-1 -: NUM_DIGITS] !== an_exp(0); k++) next_dwell(obs);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i > 0) next_dwell(obs);
            check_obs(obs);
        end
    endtask

    task automatic count_busy(input int already, output int n);
        n = already;
        while (busy && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic run_load(input int v, input string name);
        int n;
        expect_val({name, "_busy_cycles"}, W'(15));
        push_display(v, name);
        value = VALUE_W'(v);
        load  = 1'b1;
        step();
        load  = 1'b0;
        count_busy(0, n);
        check_obs(W'(n));
        collect_display();
    endtask

    initial begin
        int                    n;
        logic [W-1:0]          obs;
        logic [NUM_DIGITS-1:0] prev_an;
        logic [NUM_DIGITS-1:0] seq [5];

        // Reset held, then released; outputs stay idle until the first scan tick.
        #2 rst = 1'b0;
        repeat (3) step();
        expect_val("rst_busy", '0);
        expect_val("rst_ovf", '0);
        expect_val("rst_out", {4'b1111, 7'h7F});
        check_obs(W'(busy));
        check_obs(W'(overflow));
        check_obs({an, seg});
        rst = 1'b1;
        for (int k = 0; k < SCAN_DIV - 1; k++) begin
            step();
            expect_val($sformatf("pre_tick_%0d", k), {4'b1111, 7'h7F});
            check_obs({an, seg});
        end
        step();
        expect_val("first_tick", {4'b1110, 7'b0000001});
        check_obs({an, seg});

        run_load(1234, "v1234");
        run_load(9999, "v9999");
        run_load(7, "v7");
        run_load(0, "v0");

        // A second load while busy is ignored and must not stretch the conversion.
        expect_val("v500_busy_cycles", W'(15));
        push_display(500, "v500");
        value = VALUE_W'(500);
        load  = 1'b1;
        step();
        load  = 1'b0;
        step();
        step();
        value = VALUE_W'(42);
        load  = 1'b1;
        step();
        load  = 1'b0;
        count_busy(3, n);
        check_obs(W'(n));
        collect_display();

        run_load(10000, "v10000");
        run_load(16383, "v16383");

        // Reset mid-conversion aborts and clears the display to zeros.
        expect_val("midrst_busy", '0);
        expect_val("midrst_ovf", '0);
        expect_val("midrst_out", {4'b1111, 7'h7F});
        push_display(0, "after_rst");
        value = VALUE_W'(1234);
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (4) step();
        rst = 1'b0;
        #1;
        check_obs(W'(busy));
        check_obs(W'(overflow));
        check_obs({an, seg});
        step();
        rst = 1'b1;
        collect_display();

        // Free-running scan: each enable held exactly SCAN_DIV cycles.
        seq[0] = 4'b1101;
        seq[1] = 4'b1011;
        seq[2] = 4'b0111;
        seq[3] = 4'b1110;
        seq[4] = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            expect_val($sformatf("hold_%0d", k), W'(SCAN_DIV));
            expect_val($sformatf("scan_an_%0d", k), W'(seq[k]));
        end
        next_dwell(obs);
        for (int k = 0; k < NUM_DIGITS && obs[W-1 -: NUM_DIGITS] !== 4'b1110; k++) next_dwell(obs);
        for (int k = 0; k < 5; k++) begin
            prev_an = an;
            n = 0;
            do begin
                step();
                n++;
            end while (an === prev_an && n < 20);
            check_obs(W'(n));
            check_obs(W'(an));
        end

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
